insert_frame_length_header: RTL and testbench

Transmit-side counterpart of `get_frame_length`. It takes an Ethernet frame stream plus its separately delivered frame length, and emits one stream in which each frame is preceded by a big-endian frame-length header. The frame body, including the optional timestamp footer, passes through unchanged. The block sits upstream of any consumer that expects `ENABLE_FRAME_LENGTH_HEADER` framing. The length may arrive before, during or after its frame, so the frame body is buffered internally.

---
 rtl/frame_length_pkg.sv | 31 +++
 rtl/sync_fifo_fwft.sv | 63 ++++++
 rtl/insert_frame_length_header.sv | 158 +++++++++++++++
 tb/tb_insert_frame_length_header.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_length_pkg.sv
// Shared definitions for the frame-length header blocks: FSM encoding, default widths and
// byte-count helpers.
package frame_length_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StBody
    } fl_state_e;

    localparam int unsigned DefDataWidth        = 8;
    localparam int unsigned DefFrameLengthWidth = 16;
    localparam int unsigned DefEthFrameWidth    = 1600 * 8;
    localparam int unsigned DefTimestampWidth   = 72;
    localparam int unsigned DefFifoDepth        = 2048;

    function automatic int unsigned hdr_bytes(input int unsigned flw, input int unsigned dw);
        return flw / dw;
    endfunction

    function automatic int unsigned footer_bytes(input int unsigned en, input int unsigned tsw,
                                                 input int unsigned dw);
        return (en != 0) ? tsw / dw : 0;
    endfunction

    function automatic int unsigned max_frame_bytes(input int unsigned efw,
                                                    input int unsigned dw);
        return efw / dw;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word is visible on rd_data whenever !empty.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 2048
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] FullCount = CW'(DEPTH);

    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2
        $fatal(1, "sync_fifo_fwft: DEPTH must be a power of two");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign full    = (count == FullCount);
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/insert_frame_length_header.sv
// Prepends a big-endian frame-length header to each buffered frame. Defining
// INSERT_FRAME_LENGTH_HEADER_LENGTH_CHECK_EN adds a body-length check driving length_error.
module insert_frame_length_header
    import frame_length_pkg::*;
#(
    parameter int unsigned DATA_WIDTH              = DefDataWidth,
    parameter int unsigned FRAME_LENGTH_WIDTH      = DefFrameLengthWidth,
    parameter int unsigned ETHERNET_FRAME_WIDTH    = DefEthFrameWidth,
    parameter int unsigned ENABLE_TIMESTAMP_FOOTER = 1,
    parameter int unsigned TIMESTAMP_WIDTH         = DefTimestampWidth,
    parameter int unsigned FIFO_DEPTH              = DefFifoDepth
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
    input  logic                          s_axis_frame_length_tvalid,
    output logic                          s_axis_frame_length_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          length_error
);
    localparam int unsigned HdrBytes = hdr_bytes(FRAME_LENGTH_WIDTH, DATA_WIDTH);
    localparam int unsigned FtrBytes =
        footer_bytes(ENABLE_TIMESTAMP_FOOTER, TIMESTAMP_WIDTH, DATA_WIDTH);
    localparam int unsigned MaxBytes = max_frame_bytes(ETHERNET_FRAME_WIDTH, DATA_WIDTH);
    localparam int unsigned IdxW     = (HdrBytes > 1) ? $clog2(HdrBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(HdrBytes - 1);

    // A whole frame must fit while its length is still outstanding, else the block can deadlock.
    if (MaxBytes + FtrBytes > FIFO_DEPTH) begin : g_depth_chk
        $fatal(1, "insert_frame_length_header: FIFO_DEPTH too small for a maximum frame");
    end

    fl_state_e               state;
    logic [FRAME_LENGTH_WIDTH-1:0] len_reg;
    logic [IdxW-1:0]         hdr_idx;
    logic [DATA_WIDTH:0]     fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_rd;
    logic                    len_hs;
    logic                    out_hs;
    logic                    body_last_hs;
    logic [31:0]             hdr_shift;
    logic [FRAME_LENGTH_WIDTH-1:0] hdr_word;

    assign s_axis_tready              = rstn && !fifo_full;
    assign s_axis_frame_length_tready = (state == StIdle);
    assign len_hs       = s_axis_frame_length_tvalid && s_axis_frame_length_tready;
    assign out_hs       = m_axis_tvalid && m_axis_tready;
    assign fifo_rd      = (state == StBody) && m_axis_tready;
    assign body_last_hs = (state == StBody) && out_hs && fifo_head[DATA_WIDTH];

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_body_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (s_axis_tvalid),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= StIdle;
            len_reg <= '0;
            hdr_idx <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (len_hs) begin
                        len_reg <= s_axis_frame_length_tdata;
                        hdr_idx <= '0;
                        state   <= StHeader;
                    end
                end
                StHeader: begin
                    if (m_axis_tready) begin
                        hdr_idx <= hdr_idx + IdxW'(1);
                        if (hdr_idx == LastIdx) begin
                            state <= StBody;
                        end
                    end
                end
                StBody: begin
                    if (body_last_hs) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Header goes out most-significant byte first.
    assign hdr_shift = DATA_WIDTH * 32'(LastIdx - hdr_idx);
    assign hdr_word  = len_reg >> hdr_shift;

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        unique case (state)
            StHeader: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_word[DATA_WIDTH-1:0];
            end
            StBody: begin
                m_axis_tvalid = !fifo_empty;
                if (!fifo_empty) begin
                    m_axis_tdata = fifo_head[DATA_WIDTH-1:0];
                    m_axis_tlast = fifo_head[DATA_WIDTH];
                end
            end
            default: ;
        endcase
    end

`ifdef INSERT_FRAME_LENGTH_HEADER_LENGTH_CHECK_EN
    localparam int unsigned CntW = FRAME_LENGTH_WIDTH + 1;

    logic [CntW-1:0] body_cnt;
    logic [CntW-1:0] frame_bytes;
    logic            len_err_q;

    // Byte count including the current tlast beat, with the footer stripped off.
    assign frame_bytes  = body_cnt + CntW'(1) - CntW'(FtrBytes);
    assign length_error = len_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            body_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= body_last_hs && (frame_bytes != {1'b0, len_reg});
            if (body_last_hs) begin
                body_cnt <= '0;
            end else if ((state == StBody) && out_hs) begin
                body_cnt <= body_cnt + CntW'(1);
            end
        end
    end
`else
    assign length_error = 1'b0;
`endif

endmodule

// File: tb/tb_insert_frame_length_header.sv
// Randomized bench for insert_frame_length_header: a queue-based model predicts the output
// byte stream (header, body, footer) and the length_error pulses.
module tb_insert_frame_length_header;

    localparam int FTR = 9;
`ifdef INSERT_FRAME_LENGTH_HEADER_LENGTH_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [15:0] s_axis_frame_length_tdata;
    logic        s_axis_frame_length_tvalid;
    logic        s_axis_frame_length_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        length_error;

    always #5 clk = ~clk;

    insert_frame_length_header dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .s_axis_tdata               (s_axis_tdata),
        .s_axis_tvalid              (s_axis_tvalid),
        .s_axis_tready              (s_axis_tready),
        .s_axis_tlast               (s_axis_tlast),
        .s_axis_frame_length_tdata  (s_axis_frame_length_tdata),
        .s_axis_frame_length_tvalid (s_axis_frame_length_tvalid),
        .s_axis_frame_length_tready (s_axis_frame_length_tready),
        .m_axis_tdata               (m_axis_tdata),
        .m_axis_tvalid              (m_axis_tvalid),
        .m_axis_tready              (m_axis_tready),
        .m_axis_tlast               (m_axis_tlast),
        .length_error               (length_error)
    );

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    logic [8:0]  body_q[$];
    logic [15:0] len_q[$];
    logic [15:0] held_q[$];
    logic [8:0]  exp_q[$];
    bit          err_q[$];

    int          rdy_mode = 0;
    bit          src_gaps = 0;
    bit          len_gaps = 0;
    bit          chk_sready = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data;
    logic        prev_last;
    bit          pend_err = 0;
    bit          pend_hdr = 0;
    logic [7:0]  hdr0_exp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: output = header (MSB byte first) then body and footer verbatim, tlast on final byte.
    task automatic add_frame(input int nbytes, input logic [15:0] len_val, input bit defer);
        logic [7:0] b;
        logic [8:0] w;
        exp_q.push_back({1'b0, len_val[15:8]});
        exp_q.push_back({1'b0, len_val[7:0]});
        for (int i = 0; i < nbytes + FTR; i++) begin
            b = 8'($urandom);
            w = {(i == nbytes + FTR - 1), b};
            body_q.push_back(w);
            exp_q.push_back(w);
        end
        err_q.push_back(len_val != 16'(nbytes));
        if (defer) held_q.push_back(len_val);
        else len_q.push_back(len_val);
    endtask

    task automatic step();
        bit         b_hs;
        bit         l_hs;
        bit         m_hs;
        bit         f;
        logic [8:0] e;
        @(negedge clk);
        b_hs = s_axis_tvalid && s_axis_tready;
        l_hs = s_axis_frame_length_tvalid && s_axis_frame_length_tready;
        m_hs = m_axis_tvalid && m_axis_tready;
        if (pend_hdr) begin
            check_eq("hdr_latency_valid", m_axis_tvalid, 1);
            check_eq("hdr_latency_data", m_axis_tdata, hdr0_exp);
        end
        pend_hdr = l_hs;
        if (l_hs) hdr0_exp = s_axis_frame_length_tdata[15:8];
        if (prev_stall) begin
            check_eq("stall_valid", m_axis_tvalid, 1);
            check_eq("stall_data", m_axis_tdata, prev_data);
            check_eq("stall_last", m_axis_tlast, prev_last);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        check_eq("length_error", length_error, pend_err);
        pend_err = 1'b0;
        if (chk_sready) check_eq("s_tready_high", s_axis_tready, 1);
        if (m_hs) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", m_axis_tvalid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("tdata", m_axis_tdata, e[7:0]);
                check_eq("tlast", m_axis_tlast, e[8]);
                if (e[8] && err_q.size() != 0) begin
                    f = err_q.pop_front();
                    pend_err = ChkEn && f;
                end
            end
        end
        @(posedge clk);
        #1;
        if (b_hs) void'(body_q.pop_front());
        if (l_hs) void'(len_q.pop_front());
        if (!(s_axis_tvalid && !b_hs))
            s_axis_tvalid = (body_q.size() > 0) && (!src_gaps || $urandom_range(0, 3) != 0);
        if (body_q.size() > 0) {s_axis_tlast, s_axis_tdata} = body_q[0];
        else {s_axis_tlast, s_axis_tdata} = 9'h0;
        if (!(s_axis_frame_length_tvalid && !l_hs))
            s_axis_frame_length_tvalid = (len_q.size() > 0) &&
                                         (!len_gaps || $urandom_range(0, 2) == 0);
        s_axis_frame_length_tdata = (len_q.size() > 0) ? len_q[0] : 16'h0;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || body_q.size() != 0 || len_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
        repeat (3) step();
    endtask

    task automatic mid_reset(input string tag);
        check_eq({tag, "_pre_valid"}, m_axis_tvalid, 1);
        #1 rstn = 1'b0;
        #1;
        check_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
        check_eq({tag, "_tdata"}, m_axis_tdata, 0);
        check_eq({tag, "_tlast"}, m_axis_tlast, 0);
        check_eq({tag, "_s_tready"}, s_axis_tready, 0);
        body_q.delete(); len_q.delete(); held_q.delete(); exp_q.delete(); err_q.delete();
        s_axis_tvalid = 1'b0; s_axis_frame_length_tvalid = 1'b0;
        prev_stall = 1'b0; pend_err = 1'b0; pend_hdr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        int n;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_frame_length_tdata = '0; s_axis_frame_length_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_tvalid", m_axis_tvalid, 0);
        check_eq("rst_m_tdata", m_axis_tdata, 0);
        check_eq("rst_m_tlast", m_axis_tlast, 0);
        check_eq("rst_s_tready", s_axis_tready, 0);
        check_eq("rst_length_error", length_error, 0);
        #2 rstn = 1'b1;
        #1;
        check_eq("post_rst_s_tready", s_axis_tready, 1);
        check_eq("post_rst_len_tready", s_axis_frame_length_tready, 1);

        // Length ahead of the frame.
        add_frame(60, 16'd60, 1'b0);
        drain("t1_drain", 500);

        // Length 20 cycles after the frame; input must never stall.
        add_frame(60, 16'd60, 1'b1);
        chk_sready = 1'b1;
        n = 0;
        while (body_q.size() != 0 && n < 300) begin step(); n++; end
        check_eq("t2_body_accepted", body_q.size(), 0);
        repeat (20) step();
        chk_sready = 1'b0;
        len_q.push_back(held_q.pop_front());
        drain("t2_drain", 500);

        // Back-to-back frames with a toggling sink.
        rdy_mode = 1;
        add_frame(64, 16'd64, 1'b0);
        add_frame(1518, 16'd1518, 1'b0);
        add_frame(60, 16'd60, 1'b0);
        drain("t3_drain", 8000);

        // Fill the buffer to exactly its depth with lengths withheld.
        rdy_mode = 0;
        add_frame(1600, 16'd1600, 1'b1);
        add_frame(430, 16'd430, 1'b1);
        n = 0;
        while (body_q.size() != 0 && n < 2600) begin step(); n++; end
        check_eq("t4_fill_accepted", body_q.size(), 0);
        add_frame(10, 16'd10, 1'b1);
        repeat (5) begin
            step();
            check_eq("t4_full_tready", s_axis_tready, 0);
        end
        check_eq("t4_full_held", body_q.size(), 19);
        while (held_q.size() != 0) len_q.push_back(held_q.pop_front());
        drain("t4_drain", 5000);

        // Wrong length is forwarded verbatim; length_error only when the check is built in.
        add_frame(60, 16'd59, 1'b0);
        add_frame(60, 16'd60, 1'b0);
        drain("t5_drain", 500);

        // Randomized traffic.
        rdy_mode = 2; src_gaps = 1'b1; len_gaps = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 100);
            add_frame(n, ($urandom_range(0, 3) == 0) ? 16'(n + 1) : 16'(n), 1'b0);
        end
        drain("t6_drain", 6000);
        src_gaps = 1'b0; len_gaps = 1'b0;

        // Reset during the header, then during the body.
        rdy_mode = 3;
        add_frame(60, 16'd60, 1'b0);
        repeat (3) step();
        mid_reset("rst_hdr");
        rdy_mode = 0;
        add_frame(40, 16'd40, 1'b0);
        drain("t7_drain_a", 500);
        add_frame(60, 16'd60, 1'b0);
        repeat (20) step();
        mid_reset("rst_body");
        add_frame(50, 16'd50, 1'b0);
        drain("t7_drain_b", 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
